operand_fetch_stage: RTL and testbench

- Issue stage directly upstream of the 16-entry, 32-bit register file, and downstream of instruction decode.
- Accepts one decoded instruction at a time over a valid/ready handshake and drives the register-file read addresses and the update strobe.
- Captures the returned operands and presents them to the execute stage over a second valid/ready handshake.
- Keeps a per-register pending-write scoreboard and stalls issue on RAW/WAW hazards until write-back clears the target register.

---
 rtl/operand_fetch_stage.sv | 125 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch / issue stage with register-file read and pending-write scoreboard
module operand_fetch_stage #(
  parameter int WORD = 32,
  parameter int ADDR = 4,
  parameter int OPW  = 6,
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_opcode,
  input  logic [ADDR-1:0] in_rs_a,
  input  logic [ADDR-1:0] in_rs_b,
  input  logic [ADDR-1:0] in_rd,
  input  logic            in_use_a,
  input  logic            in_use_b,
  input  logic            in_wr,
  output logic [ADDR-1:0] rf_addr_a,
  output logic [ADDR-1:0] rf_addr_b,
  output logic            rf_update,
  input  logic [WORD-1:0] rf_a,
  input  logic [WORD-1:0] rf_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_opcode,
  output logic [ADDR-1:0] out_rd,
  output logic            out_wr,
  output logic [WORD-1:0] out_op_a,
  output logic [WORD-1:0] out_op_b,
  input  logic            wb_valid,
  input  logic [ADDR-1:0] wb_addr,
  output logic [15:0]     busy_mask,
  output logic [SCW-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, ISSUE} state_t;

  state_t      state;
  logic        use_a;
  logic        use_b;
  logic        hazard;
  logic        stall;
  logic        issue_done;
  logic [15:0] busy_next;

  // Hazard looks only at the registered scoreboard; a write-back in the same cycle does not bypass.
  assign hazard = (in_use_a & busy_mask[in_rs_a]) |
                  (in_use_b & busy_mask[in_rs_b]) |
                  (in_wr    & busy_mask[in_rd]);

  // Gated by flush so an instruction is never accepted in a cycle that would abandon it.
  assign in_ready   = (state == IDLE) & ~hazard & ~flush & ~reset;
  assign stall      = (state == IDLE) & in_valid & hazard & ~flush;
  assign issue_done = (state == ISSUE) & out_ready & ~flush;

  // Set is applied after clear so a stale write-back cannot drop a freshly issued write.
  always_comb begin
    busy_next = busy_mask;
    if (wb_valid)
      busy_next[wb_addr] = 1'b0;
    if (issue_done && out_wr)
      busy_next[out_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      use_a      <= 1'b0;
      use_b      <= 1'b0;
      rf_addr_a  <= '0;
      rf_addr_b  <= '0;
      rf_update  <= 1'b0;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_wr     <= 1'b0;
      out_op_a   <= '0;
      out_op_b   <= '0;
      busy_mask  <= '0;
      stall_cnt  <= '0;
    end else begin
      busy_mask <= busy_next;
      if (stall && (stall_cnt != {SCW{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid && in_ready) begin
              out_opcode <= in_opcode;
              out_rd     <= in_rd;
              out_wr     <= in_wr;
              use_a      <= in_use_a;
              use_b      <= in_use_b;
              rf_addr_a  <= in_rs_a;
              rf_addr_b  <= in_rs_b;
              rf_update  <= ~rf_update;
              state      <= READ;
            end
          end
          READ: state <= CAPTURE;
          CAPTURE: begin
            out_op_a  <= use_a ? rf_a : '0;
            out_op_b  <= use_b ? rf_b : '0;
            out_valid <= 1'b1;
            state     <= ISSUE;
          end
          ISSUE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [3:0]  in_rs_a = '0, in_rs_b = '0, in_rd = '0;
  logic        in_use_a = 1'b0, in_use_b = 1'b0, in_wr = 1'b0;
  logic [3:0]  rf_addr_a, rf_addr_b;
  logic        rf_update;
  logic [31:0] rf_a, rf_b;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [3:0]  out_rd;
  logic        out_wr;
  logic [31:0] out_op_a, out_op_b;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [15:0] busy_mask;
  logic [15:0] stall_cnt;

  logic [31:0] regs [16];
  assign rf_a = regs[rf_addr_a];
  assign rf_b = regs[rf_addr_b];

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_wr(in_wr),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_update(rf_update),
    .rf_a(rf_a), .rf_b(rf_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_wr(out_wr), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one instruction in flight, tracked by its age in cycles since acceptance.
  bit          m_inflight;
  int          m_age;
  logic [15:0] m_busy;
  int          m_stall;
  bit          m_upd;
  logic [3:0]  m_addr_a, m_addr_b, m_rd;
  logic [5:0]  m_opc;
  bit          m_wr;
  logic [31:0] m_exp_a, m_exp_b, m_op_a, m_op_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard_of(input logic [15:0] b);
    return (in_use_a && b[in_rs_a]) || (in_use_b && b[in_rs_b]) || (in_wr && b[in_rd]);
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_age = 0; m_busy = '0; m_stall = 0; m_upd = 0;
    m_addr_a = '0; m_addr_b = '0; m_rd = '0; m_opc = '0; m_wr = 0;
    m_exp_a = '0; m_exp_b = '0; m_op_a = '0; m_op_b = '0;
  endtask

  task automatic model_update();
    bit hz, acc, done;
    hz   = hazard_of(m_busy);
    acc  = !m_inflight && in_valid && !hz && !flush;
    done = m_inflight && m_age == 3 && out_ready && !flush;
    if (!m_inflight && in_valid && hz && !flush && m_stall < 65535)
      m_stall++;
    if (wb_valid) m_busy[wb_addr] = 1'b0;
    if (done && m_wr) m_busy[m_rd] = 1'b1;
    if (flush || done) begin
      m_inflight = 0;
    end else if (m_inflight && m_age < 3) begin
      if (m_age == 2) begin
        m_op_a = m_exp_a;
        m_op_b = m_exp_b;
      end
      m_age++;
    end else if (acc) begin
      m_inflight = 1; m_age = 1; m_upd = !m_upd;
      m_addr_a = in_rs_a; m_addr_b = in_rs_b;
      m_rd = in_rd; m_opc = in_opcode; m_wr = in_wr;
      m_exp_a = in_use_a ? regs[in_rs_a] : 32'h0;
      m_exp_b = in_use_b ? regs[in_rs_b] : 32'h0;
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready},
        {31'b0, !reset && !flush && !m_inflight && !hazard_of(m_busy)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_inflight && m_age == 3});
    chk("busy_mask", {16'b0, busy_mask}, {16'b0, m_busy});
    chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
    chk("rf_update", {31'b0, rf_update}, {31'b0, m_upd});
    chk("rf_addr", {24'b0, rf_addr_a, rf_addr_b}, {24'b0, m_addr_a, m_addr_b});
    chk("out_fields", {21'b0, out_opcode, out_rd, out_wr}, {21'b0, m_opc, m_rd, m_wr});
    chk("out_op_a", out_op_a, m_op_a);
    chk("out_op_b", out_op_b, m_op_b);
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
  endtask

  task automatic set_inst(input logic [5:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rd, input bit ua, input bit ub, input bit wr);
    in_opcode = opc; in_rs_a = ra; in_rs_b = rb; in_rd = rd;
    in_use_a = ua; in_use_b = ub; in_wr = wr; in_valid = 1'b1;
    #1;
  endtask

  // Accept the presented instruction and advance to ISSUE (three edges).
  task automatic run_to_issue();
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[2] = 32'h11; regs[5] = 32'h22; regs[9] = 32'hFFFF_FFFF;

    #1 reset = 1'b1;
    model_reset();
    step();
    chk("rst_busy", {16'b0, busy_mask}, 32'h0);
    chk("rst_stall", {16'b0, stall_cnt}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Basic issue of R2/R5 -> R7
    set_inst(6'h15, 4'd2, 4'd5, 4'd7, 1, 1, 1);
    chk("basic_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("basic_lat1", {31'b0, out_valid}, 32'h0);
    step();
    chk("basic_lat2", {31'b0, out_valid}, 32'h0);
    step();
    chk("basic_valid", {31'b0, out_valid}, 32'h1);
    chk("basic_op_a", out_op_a, 32'h11);
    chk("basic_op_b", out_op_b, 32'h22);
    handshake();
    chk("basic_busy", {16'b0, busy_mask}, 32'h0080);

    // RAW stall on R7 until write-back
    set_inst(6'h01, 4'd7, 4'd0, 4'd2, 1, 0, 0);
    chk("raw_ready", {31'b0, in_ready}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("raw_stall", {16'b0, stall_cnt}, i);
    end
    wb_valid = 1'b1; wb_addr = 4'd7;
    step();
    wb_valid = 1'b0;
    #1;
    chk("raw_wb_busy", {16'b0, busy_mask}, 32'h0);
    chk("raw_wb_stall", {16'b0, stall_cnt}, 32'd4);
    chk("raw_accept_ready", {31'b0, in_ready}, 32'h1);
    run_to_issue();
    chk("raw_stall_stop", {16'b0, stall_cnt}, 32'd4);
    handshake();

    // Set wins over simultaneous write-back clear
    set_inst(6'h02, 4'd0, 4'd0, 4'd3, 0, 0, 1);
    run_to_issue();
    handshake();
    chk("sim_busy_pre", {16'b0, busy_mask}, 32'h0008);
    wb_valid = 1'b1; wb_addr = 4'd3;
    step();
    wb_valid = 1'b0;
    set_inst(6'h03, 4'd1, 4'd1, 4'd3, 0, 0, 1);
    run_to_issue();
    wb_valid = 1'b1; wb_addr = 4'd3;
    handshake();
    wb_valid = 1'b0;
    chk("sim_busy", {16'b0, busy_mask}, 32'h0008);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;

    // Back-pressure in ISSUE
    set_inst(6'h2A, 4'd2, 4'd5, 4'd9, 1, 1, 0);
    run_to_issue();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_op_a", out_op_a, 32'h11);
      chk("bp_op_b", out_op_b, 32'h22);
      chk("bp_opcode", {26'b0, out_opcode}, 32'h2A);
      chk("bp_ready", {31'b0, in_ready}, 32'h0);
      step();
    end
    handshake();
    chk("bp_done", {31'b0, out_valid}, 32'h0);
    step();
    chk("bp_single", {31'b0, out_valid}, 32'h0);

    // Flush in CAPTURE
    set_inst(6'h03, 4'd1, 4'd1, 4'd4, 1, 1, 1);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_busy4", {31'b0, busy_mask[4]}, 32'h0);
      step();
    end
    set_inst(6'h04, 4'd5, 4'd2, 4'd6, 1, 1, 0);
    chk("flush_next_ready", {31'b0, in_ready}, 32'h1);
    run_to_issue();
    chk("flush_next_a", out_op_a, 32'h22);
    chk("flush_next_b", out_op_b, 32'h11);
    handshake();

    // Use-bit masking
    set_inst(6'h05, 4'd9, 4'd9, 4'd0, 0, 1, 0);
    run_to_issue();
    chk("mask_op_a", out_op_a, 32'h0);
    chk("mask_op_b", out_op_b, 32'hFFFF_FFFF);
    handshake();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_opcode = 6'($urandom);
      in_rs_a   = 4'($urandom); in_rs_b = 4'($urandom); in_rd = 4'($urandom);
      in_use_a  = 1'($urandom); in_use_b = 1'($urandom); in_wr = 1'($urandom);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_addr   = 4'($urandom);
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // Stall counter saturation
    do_reset();
    set_inst(6'h06, 4'd0, 4'd0, 4'd1, 0, 0, 1);
    run_to_issue();
    handshake();
    chk("sat_busy", {16'b0, busy_mask}, 32'h0002);
    set_inst(6'h07, 4'd1, 4'd0, 4'd0, 1, 0, 0);
    repeat (65539) step();
    chk("sat_stall", {16'b0, stall_cnt}, 32'hFFFF);
    in_valid = 1'b0;

    // Reset in the middle of ISSUE
    set_inst(6'h08, 4'd2, 4'd5, 4'd12, 1, 1, 1);
    run_to_issue();
    chk("mid_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_ops", out_op_a | out_op_b, 32'h0);
    chk("mid_rst_busy", {16'b0, busy_mask}, 32'h0);
    chk("mid_rst_stall", {16'b0, stall_cnt}, 32'h0);
    chk("mid_rst_fields", {19'b0, out_opcode, out_rd, out_wr, rf_update, in_ready},
        32'h0);
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
